// File: rtl/logicnet_ctrl_pkg.sv
// Shared constants and helpers for the LogicNet stream controller.
// Defaults describe the classification sample network's generated pipeline.
package logicnet_ctrl_pkg;

    localparam int LN_IN_W    = 16;
    localparam int LN_OUT_W   = 2;
    localparam int LN_LATENCY = 3;
    localparam int LN_DEPTH   = 4;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/logicnet_result_fifo.sv
// First-word-fall-through result buffer with synchronous flush.
// Pointers wrap at DEPTH, so DEPTH does not have to be a power of two.
module logicnet_result_fifo
    import logicnet_ctrl_pkg::*;
#(
    parameter int  OUT_W = LN_OUT_W,
    parameter int  DEPTH = LN_DEPTH,
    localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1,
    localparam int CNT_W = clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [OUT_W-1:0] i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [OUT_W-1:0] o_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [OUT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_push  = i_push && !i_flush;
    assign w_pop   = i_pop && !i_flush;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Full-with-simultaneous-pop is legal; only an unmatched push into a full buffer is not.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_push && o_full && !i_pop && !i_flush));
    a_no_underflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_pop && o_empty && !i_flush));

endmodule

// File: rtl/logicnet_stream_ctrl.sv
// Valid/ready wrapper around a free-running LogicNet LUT pipeline.
// Credits bound in-flight plus buffered samples so results are never dropped.
module logicnet_stream_ctrl
    import logicnet_ctrl_pkg::*;
#(
    parameter int  IN_W    = LN_IN_W,
    parameter int  OUT_W   = LN_OUT_W,
    parameter int  LATENCY = LN_LATENCY,
    parameter int  DEPTH   = LN_DEPTH,
    localparam int OCC_W   = clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    input  logic [IN_W-1:0]  i_s_data,
    output logic [IN_W-1:0]  o_pipe_in_data,
    input  logic [OUT_W-1:0] i_pipe_out_data,
    output logic             o_m_valid,
    input  logic             i_m_ready,
    output logic [OUT_W-1:0] o_m_data,
    input  logic             i_flush,
    output logic [OCC_W-1:0] o_occupancy,
    output logic             o_busy
);

    logic [LATENCY:0] r_vld;
    logic [IN_W-1:0]  r_pipe_in;
    logic [OCC_W-1:0] r_occupancy;
    logic             w_accept;
    logic             w_pop;
    logic             w_fifo_empty;
    logic             w_fifo_full;
    logic [OCC_W-1:0] w_fifo_count;

    // Ready depends only on registered occupancy, never on i_m_ready.
    assign o_s_ready      = !i_rst && !i_flush && (r_occupancy < OCC_W'(DEPTH));
    assign w_accept       = i_s_valid && o_s_ready;
    assign w_pop          = o_m_valid && i_m_ready && !i_flush;
    assign o_m_valid      = !w_fifo_empty;
    assign o_pipe_in_data = r_pipe_in;
    assign o_occupancy    = r_occupancy;
    assign o_busy         = (r_occupancy != '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld       <= '0;
            r_pipe_in   <= '0;
            r_occupancy <= '0;
        end else if (i_flush) begin
            r_vld       <= '0;
            r_occupancy <= '0;
        end else begin
            r_vld       <= {r_vld[LATENCY-1:0], w_accept};
            if (w_accept) r_pipe_in <= i_s_data;
            r_occupancy <= r_occupancy + OCC_W'(w_accept) - OCC_W'(w_pop);
        end
    end

    logicnet_result_fifo #(
        .OUT_W (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (r_vld[LATENCY]),
        .i_push_data (i_pipe_out_data),
        .i_pop       (w_pop),
        .i_flush     (i_flush),
        .o_data      (o_m_data),
        .o_count     (w_fifo_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    a_fifo_within_credit: assert property (@(posedge i_clk) disable iff (i_rst)
        (w_fifo_count <= r_occupancy) && (r_occupancy <= OCC_W'(DEPTH)));
    a_full_means_all_buffered: assert property (@(posedge i_clk) disable iff (i_rst)
        !w_fifo_full || (r_occupancy == OCC_W'(DEPTH)));

endmodule

// File: tb/tb_logicnet_stream_ctrl.sv
// Directed plus random bench for logicnet_stream_ctrl with a 3-stage x[1:0] pipeline model.
module tb_logicnet_stream_ctrl;

    localparam int IN_W    = 16;
    localparam int OUT_W   = 2;
    localparam int LATENCY = 3;
    localparam int DEPTH   = 4;

    logic             clk;
    logic             rst;
    logic             s_valid;
    logic             s_ready;
    logic [IN_W-1:0]  s_data;
    logic [IN_W-1:0]  pipe_in_data;
    logic [OUT_W-1:0] pipe_out_data;
    logic             m_valid;
    logic             m_ready;
    logic [OUT_W-1:0] m_data;
    logic             flush;
    logic [2:0]       occupancy;
    logic             busy;

    logic [OUT_W-1:0] p1, p2, p3;

    int checks;
    int failures;

    logic [OUT_W-1:0] sb [$];
    logic [LATENCY:0] exp_vld;
    int               exp_fifo;
    int               exp_occ;
    logic             last_acc;
    int               dut_hs;

    logicnet_stream_ctrl #(
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_s_valid       (s_valid),
        .o_s_ready       (s_ready),
        .i_s_data        (s_data),
        .o_pipe_in_data  (pipe_in_data),
        .i_pipe_out_data (pipe_out_data),
        .o_m_valid       (m_valid),
        .i_m_ready       (m_ready),
        .o_m_data        (m_data),
        .i_flush         (flush),
        .o_occupancy     (occupancy),
        .o_busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        p1 <= pipe_in_data[OUT_W-1:0];
        p2 <= p1;
        p3 <= p2;
    end
    assign pipe_out_data = p3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        exp_vld  = '0;
        exp_fifo = 0;
        exp_occ  = 0;
    endtask

    // One clock: check handshake inputs against the model, advance both, check state after the edge.
    task automatic cycle();
        logic exp_ready;
        logic acc;
        logic pop;
        logic [OUT_W-1:0] want;
        #1;
        exp_ready = !flush && (exp_occ < DEPTH);
        chk("s_ready", s_ready, exp_ready);
        if (s_valid && s_ready) dut_hs++;
        acc = s_valid && exp_ready;
        pop = (exp_fifo != 0) && m_ready && !flush;
        last_acc = acc;
        if (pop) begin
            chk("sb_nonempty_on_pop", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                want = sb.pop_front();
                chk("m_data", m_data, want);
            end
        end
        if (flush) begin
            model_reset();
        end else begin
            if (acc) sb.push_back(s_data[OUT_W-1:0]);
            exp_fifo = exp_fifo + int'(exp_vld[LATENCY]) - int'(pop);
            exp_vld  = {exp_vld[LATENCY-1:0], acc};
            exp_occ  = exp_occ + int'(acc) - int'(pop);
        end
        @(posedge clk);
        @(negedge clk);
        chk("occupancy", occupancy, exp_occ);
        chk("occ_le_depth", occupancy <= DEPTH, 1);
        chk("m_valid", m_valid, exp_fifo != 0);
        chk("busy", busy, exp_occ != 0);
    endtask

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        dut_hs   = 0;
        last_acc = 1'b0;
        model_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        flush   = 1'b0;

        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_pipe_in", pipe_in_data, 0);
        chk("rst_m_data", m_data, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single sample
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'h00A5;
        cycle();
        chk("s1_pipe_in", pipe_in_data, 16'h00A5);
        s_valid = 1'b0;
        repeat (6) cycle();

        // Back-to-back
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(i);
            cycle();
        end
        s_valid = 1'b0;
        repeat (6) cycle();

        // Backpressure: credits stop acceptance at DEPTH
        m_ready = 1'b0;
        dut_hs  = 0;
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(8 + i * 3);
            cycle();
        end
        s_valid = 1'b0;
        chk("bp_accepted", dut_hs, 4);
        chk("bp_occupancy", occupancy, 4);
        m_ready = 1'b1;
        repeat (6) cycle();

        // Flush with one result buffered and two in flight
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 16'h0011; cycle();
        s_valid = 1'b0; cycle();
        s_valid = 1'b1; s_data = 16'h0012; cycle();
        s_data  = 16'h0013; cycle();
        s_valid = 1'b0; cycle();
        chk("pre_flush_m_valid", m_valid, 1);
        flush   = 1'b1;
        m_ready = 1'b1;
        s_valid = 1'b1;
        cycle();
        flush   = 1'b0;
        s_valid = 1'b0;
        chk("post_flush_occ", occupancy, 0);
        repeat (6) cycle();

        // Asynchronous reset with three samples outstanding
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(16'h0020 + i);
            cycle();
        end
        s_valid = 1'b0;
        repeat (2) cycle();
        chk("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_m_valid", m_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_s_ready", s_ready, 0);
        chk("arst_occupancy", occupancy, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'h00A6;
        cycle();
        chk("arst_pipe_in", pipe_in_data, 16'h00A6);
        s_valid = 1'b0;
        repeat (6) cycle();

        // Random traffic with 50% downstream readiness
        n = 0;
        for (int c = 0; c < 3000 && n < 200; c++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = 16'($urandom);
            m_ready = 1'($urandom_range(0, 1));
            cycle();
            if (last_acc) n++;
        end
        s_valid = 1'b0;
        chk("rand_accepted", n, 200);
        m_ready = 1'b1;
        repeat (10) cycle();
        chk("drain_sb_empty", sb.size(), 0);
        chk("drain_occupancy", occupancy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
